param_datapath_core: RTL
========================

Name: param_datapath_core

Overview:
- Parametrised successor to the current 32-bit bus datapath.
- Holds the general register file, PC, MDR, Y, Z (ZHI/ZLO), HI, LO and the shared internal bus.
- Width and register count are generic. Bus source is an encoded select rather than a one-hot encoder.
- Adds an iterative signed multiply/divide engine with start/busy/done handshake; logic ops are single-cycle.
- Sits between the control unit (drives selects/enables) and memory (MAR/RAM outside this block).

Parameters:
DATA_W, 32, datapath/bus width (>=8, power of 2)
NUM_REGS, 16, general registers R0..R(NUM_REGS-1)
REG_AW, 4, register index width, 2^REG_AW >= NUM_REGS

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  synchronous active-high reset
bus_src  in  3  bus source: 0 REG, 1 HI, 2 LO, 3 ZHI, 4 ZLO, 5 PC, 6 MDR, 7 C_IMM
reg_out_sel  in  REG_AW  register driven when bus_src=REG
ba_out  in  1  forces R0 read as 0 on bus
reg_in_en  in  1  write bus into register reg_in_sel
reg_in_sel  in  REG_AW  destination register
y_in, hi_in, lo_in, pc_in, inc_pc  in  1 each  load enables
mdr_in  in  1  MDR load enable
mdr_read  in  1  MDR source: 1 mem_data_in, 0 bus
mem_data_in  in  DATA_W  memory read data
c_imm  in  DATA_W  sign-extended immediate from select/encode
alu_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHRA,6 SHL,7 ROR,8 ROL,9 NEG,10 NOT,11 MUL,12 DIV, 13-15 reserved
z_in  in  1  latch single-cycle ALU result into Z
alu_start  in  1  start MUL/DIV (ignored for other ops)
alu_busy  out  1  iterative op in progress
alu_done  out  1  one-cycle pulse, Z valid
div_zero  out  1  last DIV had zero divisor (sticky until next start)
bus_out  out  DATA_W  current bus value (combinational)
pc_out, mdr_out  out  DATA_W  PC and MDR contents

Behaviour:
- clr: every register (R*, PC, MDR, Y, ZHI, ZLO, HI, LO) to 0; alu_busy=0, alu_done=0, div_zero=0. Applies mid-operation: iterative op aborts, Z unchanged from reset value 0.
- Bus: combinational mux per bus_src. REG with reg_out_sel>=NUM_REGS drives 0. ba_out=1 with reg_out_sel=0 drives 0; ba_out is ignored for other sources.
- Register writes: one cycle, bus value captured at edge. Writes to index >=NUM_REGS are dropped. Write and read of the same register in one cycle: bus shows the old value.
- PC: pc_in loads bus; otherwise inc_pc adds 1 mod 2^DATA_W; pc_in has priority.
- MDR: mdr_in loads mem_data_in if mdr_read, else bus.
- Operands: A = Y, B = bus.
- Single-cycle ops: on z_in, ZLO = result, ZHI = 0. ADD/SUB wrap mod 2^DATA_W. Shift/rotate amount = B[log2(DATA_W)-1:0]. SHR is logical, SHRA is arithmetic. NEG = two's complement of B. NOT = ~B. Reserved op with z_in: ZLO=0, ZHI=0.
- MUL/DIV: alu_start with op 11/12 while idle latches A, B and op.
  - alu_busy high from next cycle for exactly DATA_W cycles.
  - On the final edge Z is written; alu_done=1 and alu_busy=0 the following cycle.
  - Total start-to-done = DATA_W+1 cycles.
  - MUL: signed radix-2 Booth; {ZHI,ZLO} = full 2*DATA_W signed product.
  - DIV: signed restoring; A/B truncates toward zero; ZLO = quotient, ZHI = remainder (sign of dividend).
  - DIV with B=0: ZLO = all ones, ZHI = A, div_zero=1, same latency.
- Handshake: alu_start while busy ignored; z_in while busy ignored. alu_start in the alu_done cycle is accepted (back-to-back). z_in and alu_start in the same idle cycle with op MUL/DIV: start wins, Z untouched. Operand registers Y and bus may change freely during busy.
- HI/LO load from bus only; the control unit moves ZHI/ZLO through the bus.

Test Plan:
- Reset: load R3=0xDEADBEEF, assert clr one cycle -> all regs, PC, Z read 0; alu_busy=0.
- ADD/SHRA: Y=0x7FFFFFFF, bus=1, ADD, z_in -> ZLO=0x80000000, ZHI=0. Y=0x80000000, bus=4, SHRA -> ZLO=0xF8000000.
- MUL: Y=-7 (0xFFFFFFF9), bus=6, start -> busy 32 cycles, done at cycle 33; ZHI=0xFFFFFFFF, ZLO=0xFFFFFFD6.
- DIV: Y=-17, bus=5 -> ZLO=0xFFFFFFFD (-3), ZHI=0xFFFFFFFE (-2). Y=9, bus=0 -> ZLO=0xFFFFFFFF, ZHI=9, div_zero=1.
- Edge handshake: start during busy ignored; start in done cycle accepted; clr at busy cycle 10 -> busy=0 next cycle, no done pulse.
- Bus/BAout/PC: R0=0x55, ba_out=1, bus_src=REG, sel 0 -> bus=0. pc_in and inc_pc with bus=0x100 -> PC=0x100. PC=0xFFFFFFFF with inc_pc -> PC=0.

Source files
------------

// File: rtl/param_datapath_core.sv
// Parametrised bus datapath: register file, PC/MDR/Y/Z/HI/LO, a shared internal bus,
// single-cycle logic ALU and an iterative signed Booth multiply / restoring divide engine.
module param_datapath_core #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [2:0]        bus_src,
    input  logic [REG_AW-1:0] reg_out_sel,
    input  logic              ba_out,
    input  logic              reg_in_en,
    input  logic [REG_AW-1:0] reg_in_sel,
    input  logic              y_in,
    input  logic              hi_in,
    input  logic              lo_in,
    input  logic              pc_in,
    input  logic              inc_pc,
    input  logic              mdr_in,
    input  logic              mdr_read,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] c_imm,
    input  logic [3:0]        alu_op,
    input  logic              z_in,
    input  logic              alu_start,
    output logic              alu_busy,
    output logic              alu_done,
    output logic              div_zero,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] mdr_out
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [REG_AW:0] NUM_REGS_L = (REG_AW+1)'(NUM_REGS);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4,  OP_SHRA = 4'd5, OP_SHL = 4'd6,  OP_ROR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8,  OP_NEG = 4'd9,  OP_NOT = 4'd10, OP_MUL = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd12;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] pc_q, mdr_q, y_q, hi_q, lo_q, zhi_q, zlo_q;
    logic [DATA_W-1:0] pc_d, mdr_d, zhi_d, zlo_d;
    state_t            state_q;
    logic [SH_W-1:0]   cnt_q;
    logic              done_q, dz_q, is_div_q, qneg_q, rneg_q, qm1_q;
    logic [DATA_W:0]   acc_q;
    logic [DATA_W-1:0] wq_q, m_q, a_q;

    logic [DATA_W-1:0]   bus_s, res_s, abs_a_s, abs_b_s, step_wq_s, quo_s, rem_s;
    logic [2*DATA_W-1:0] rotr_s, rotl_s;
    logic [SH_W-1:0]     sh_s;
    logic [DATA_W:0]     booth_sum_s, step_acc_s, div_rs_s;
    logic                is_md_s, start_s, last_s, div_ge_s;

    // Internal bus source mux; out-of-range or BAout-masked R0 reads drive zero
    always_comb begin
        bus_s = '0;
        case (bus_src)
            3'd0: begin
                if (({1'b0, reg_out_sel} < NUM_REGS_L) && !(ba_out && (reg_out_sel == '0))) begin
                    bus_s = regs_q[reg_out_sel];
                end else begin
                    bus_s = '0;
                end
            end
            3'd1:    bus_s = hi_q;
            3'd2:    bus_s = lo_q;
            3'd3:    bus_s = zhi_q;
            3'd4:    bus_s = zlo_q;
            3'd5:    bus_s = pc_q;
            3'd6:    bus_s = mdr_q;
            3'd7:    bus_s = c_imm;
            default: bus_s = '0;
        endcase
    end

    // Single-cycle ALU: A = Y, B = bus
    always_comb begin
        sh_s   = bus_s[SH_W-1:0];
        rotr_s = {y_q, y_q} >> sh_s;
        rotl_s = {y_q, y_q} << sh_s;
        case (alu_op)
            OP_ADD:  res_s = y_q + bus_s;
            OP_SUB:  res_s = y_q - bus_s;
            OP_AND:  res_s = y_q & bus_s;
            OP_OR:   res_s = y_q | bus_s;
            OP_SHR:  res_s = y_q >> sh_s;
            OP_SHRA: res_s = $signed(y_q) >>> sh_s;
            OP_SHL:  res_s = y_q << sh_s;
            OP_ROR:  res_s = rotr_s[DATA_W-1:0];
            OP_ROL:  res_s = rotl_s[2*DATA_W-1:DATA_W];
            OP_NEG:  res_s = '0 - bus_s;
            OP_NOT:  res_s = ~bus_s;
            default: res_s = '0;
        endcase
    end

    // One iteration of the engine: Booth add/sub + arithmetic shift, or restoring shift/subtract
    always_comb begin
        is_md_s = (alu_op == OP_MUL) || (alu_op == OP_DIV);
        start_s = alu_start && is_md_s && (state_q == ST_IDLE);
        last_s  = (cnt_q == SH_W'(DATA_W - 1));
        abs_a_s = y_q[DATA_W-1] ? ('0 - y_q) : y_q;
        abs_b_s = bus_s[DATA_W-1] ? ('0 - bus_s) : bus_s;
        case ({wq_q[0], qm1_q})
            2'b01:   booth_sum_s = acc_q + {m_q[DATA_W-1], m_q};
            2'b10:   booth_sum_s = acc_q - {m_q[DATA_W-1], m_q};
            default: booth_sum_s = acc_q;
        endcase
        div_rs_s = {acc_q[DATA_W-1:0], wq_q[DATA_W-1]};
        div_ge_s = (div_rs_s >= {1'b0, m_q});
        if (is_div_q) begin
            step_acc_s = div_ge_s ? (div_rs_s - {1'b0, m_q}) : div_rs_s;
            step_wq_s  = {wq_q[DATA_W-2:0], div_ge_s};
        end else begin
            step_acc_s = {booth_sum_s[DATA_W], booth_sum_s[DATA_W:1]};
            step_wq_s  = {booth_sum_s[0], wq_q[DATA_W-1:1]};
        end
        quo_s = qneg_q ? ('0 - step_wq_s) : step_wq_s;
        rem_s = rneg_q ? ('0 - step_acc_s[DATA_W-1:0]) : step_acc_s[DATA_W-1:0];
    end

    // Next-state for Z, PC and MDR; a MUL/DIV start in the same cycle as z_in leaves Z alone
    always_comb begin
        zhi_d = zhi_q;
        zlo_d = zlo_q;
        if ((state_q == ST_RUN) && last_s) begin
            if (!is_div_q) begin
                zhi_d = step_acc_s[DATA_W-1:0];
                zlo_d = step_wq_s;
            end else if (m_q == '0) begin
                zhi_d = a_q;
                zlo_d = '1;
            end else begin
                zhi_d = rem_s;
                zlo_d = quo_s;
            end
        end else if ((state_q == ST_IDLE) && z_in && !(alu_start && is_md_s)) begin
            zhi_d = '0;
            zlo_d = res_s;
        end else begin
            zhi_d = zhi_q;
            zlo_d = zlo_q;
        end
        if (pc_in) begin
            pc_d = bus_s;
        end else if (inc_pc) begin
            pc_d = pc_q + DATA_W'(1);
        end else begin
            pc_d = pc_q;
        end
        if (mdr_in) begin
            mdr_d = mdr_read ? mem_data_in : bus_s;
        end else begin
            mdr_d = mdr_q;
        end
    end

    // Architectural registers
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pc_q  <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_in_en && (reg_in_sel == REG_AW'(i))) regs_q[i] <= bus_s;
            end
            pc_q  <= pc_d;
            mdr_q <= mdr_d;
            zhi_q <= zhi_d;
            zlo_q <= zlo_d;
            if (y_in)  y_q  <= bus_s;
            if (hi_in) hi_q <= bus_s;
            if (lo_in) lo_q <= bus_s;
        end
    end

    // Multiply/divide sequencer: operands latched at start, DATA_W iterations, then done pulse
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            wq_q     <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q  <= ST_RUN;
                        cnt_q    <= '0;
                        dz_q     <= 1'b0;
                        acc_q    <= '0;
                        qm1_q    <= 1'b0;
                        a_q      <= y_q;
                        is_div_q <= (alu_op == OP_DIV);
                        qneg_q   <= y_q[DATA_W-1] ^ bus_s[DATA_W-1];
                        rneg_q   <= y_q[DATA_W-1];
                        wq_q     <= (alu_op == OP_DIV) ? abs_a_s : y_q;
                        m_q      <= (alu_op == OP_DIV) ? abs_b_s : bus_s;
                    end
                end
                ST_RUN: begin
                    acc_q <= step_acc_s;
                    wq_q  <= step_wq_s;
                    qm1_q <= wq_q[0];
                    cnt_q <= cnt_q + SH_W'(1);
                    if (last_s) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                        dz_q    <= is_div_q && (m_q == '0);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_busy = (state_q == ST_RUN);
    assign alu_done = done_q;
    assign div_zero = dz_q;
    assign bus_out  = bus_s;
    assign pc_out   = pc_q;
    assign mdr_out  = mdr_q;
endmodule
